// File: rtl/fp_mul_norm_round_if.sv
// Handshake bundle between the FP32 multiply stage, the normalise/round stage and the consumer.
// The slave view belongs to fp_mul_norm_round; the master view belongs to whoever drives it.
interface fp_mul_norm_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [8:0]  in_exp;
    logic [47:0] in_product;
    logic        in_exception;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_overflow;
    logic        out_underflow;
    logic        out_exception;

    modport slave (
        input  in_valid,
        input  in_sign,
        input  in_exp,
        input  in_product,
        input  in_exception,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_result,
        output out_overflow,
        output out_underflow,
        output out_exception
    );

    modport master (
        output in_valid,
        output in_sign,
        output in_exp,
        output in_product,
        output in_exception,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_result,
        input  out_overflow,
        input  out_underflow,
        input  out_exception
    );
endinterface

// File: rtl/fp_mul_norm_round.sv
// FP32 multiplier back end: normalise the 48-bit product, round to nearest-even, pack.
// Two registered stages with valid/ready on both sides; each stage refills as it drains.
module fp_mul_norm_round #(
    parameter bit          FLUSH_DENORM = 1'b1,
    parameter logic [31:0] QNAN         = 32'h7FC00000
) (
    input logic                clk,
    input logic                reset,
    fp_mul_norm_round_if.slave bus
);

    // Handshake
    logic s1_valid_q;
    logic out_valid_q;
    logic s2_advance;
    logic s1_advance;
    logic in_ready;
    logic in_fire;

    always_comb begin
        s2_advance = !out_valid_q || bus.out_ready;
        s1_advance = s1_valid_q && s2_advance;
        in_ready   = !s1_valid_q || s1_advance;
        in_fire    = bus.in_valid && in_ready;
    end

    // Stage 1: normalise
    logic               n_sign;
    logic               n_exc;
    logic [22:0]        n_mant;
    logic               n_guard;
    logic               n_sticky;
    logic signed [10:0] n_exp;
    logic [10:0]        n_exp_ext;

    always_comb begin
        n_sign = bus.in_sign;
        n_exc  = bus.in_exception;
        if (bus.in_product[47]) begin
            n_mant   = bus.in_product[46:24];
            n_guard  = bus.in_product[23];
            n_sticky = |bus.in_product[22:0];
        end else begin
            n_mant   = bus.in_product[45:23];
            n_guard  = bus.in_product[22];
            n_sticky = |bus.in_product[21:0];
        end
        // Exponent sums 385..511 are wrapped negatives; {2'b11, x} == x - 512 in 11 bits.
        n_exp_ext = (bus.in_exp >= 9'd385) ? {2'b11, bus.in_exp} : {2'b00, bus.in_exp};
        n_exp     = n_exp_ext + {10'b0, bus.in_product[47]};
    end

    logic               s1_sign_q;
    logic               s1_exc_q;
    logic [22:0]        s1_mant_q;
    logic               s1_guard_q;
    logic               s1_sticky_q;
    logic signed [10:0] s1_exp_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_sign_q   <= n_sign;
            s1_exc_q    <= n_exc;
            s1_mant_q   <= n_mant;
            s1_guard_q  <= n_guard;
            s1_sticky_q <= n_sticky;
            s1_exp_q    <= n_exp;
        end
    end

    // Stage 2: round to nearest-even and classify
    logic               round_up;
    logic [23:0]        mant_r;
    logic signed [10:0] e_r;
    logic [31:0]        result_d;
    logic               overflow_d;
    logic               underflow_d;
    logic               exception_d;

    always_comb begin
        round_up = s1_guard_q && (s1_sticky_q || s1_mant_q[0]);
        mant_r   = {1'b0, s1_mant_q} + {23'b0, round_up};
        // A carry out of the mantissa leaves mant_r[22:0] == 0, i.e. 1.0 at the next exponent.
        e_r      = s1_exp_q + {10'b0, mant_r[23]};

        result_d    = {s1_sign_q, e_r[7:0], mant_r[22:0]};
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
        exception_d = 1'b0;
        if (s1_exc_q) begin
            result_d    = QNAN;
            exception_d = 1'b1;
        end else if (e_r >= 11'sd255) begin
            result_d   = {s1_sign_q, 8'hFF, 23'h0};
            overflow_d = 1'b1;
        end else if (FLUSH_DENORM && (e_r <= 11'sd0)) begin
            result_d    = {s1_sign_q, 31'h0};
            underflow_d = 1'b1;
        end
    end

    logic [31:0] out_result_q;
    logic        out_overflow_q;
    logic        out_underflow_q;
    logic        out_exception_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_q     <= 1'b0;
            out_result_q    <= 32'h0;
            out_overflow_q  <= 1'b0;
            out_underflow_q <= 1'b0;
            out_exception_q <= 1'b0;
        end else if (s2_advance) begin
            out_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_result_q    <= result_d;
                out_overflow_q  <= overflow_d;
                out_underflow_q <= underflow_d;
                out_exception_q <= exception_d;
            end
        end
    end

    assign bus.in_ready      = in_ready;
    assign bus.out_valid     = out_valid_q;
    assign bus.out_result    = out_result_q;
    assign bus.out_overflow  = out_overflow_q;
    assign bus.out_underflow = out_underflow_q;
    assign bus.out_exception = out_exception_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// Directed bench for fp_mul_norm_round: hand-computed FP32 vectors, backpressure and reset cases.
module tb_fp_mul_norm_round;

    logic clk;
    logic reset;

    fp_mul_norm_round_if bus_if ();

    fp_mul_norm_round dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] flags();
        return {29'b0, bus_if.out_overflow, bus_if.out_underflow, bus_if.out_exception};
    endfunction

    // One item through an empty pipeline; checks the two-cycle latency and the packed result.
    task automatic run_one(input string tag, input logic sign, input logic [8:0] e,
                           input logic [47:0] prod, input logic exc,
                           input logic [31:0] want_res, input logic [2:0] want_flags);
        @(negedge clk);
        bus_if.out_ready    = 1'b1;
        bus_if.in_valid     = 1'b1;
        bus_if.in_sign      = sign;
        bus_if.in_exp       = e;
        bus_if.in_product   = prod;
        bus_if.in_exception = exc;
        #1;
        check({tag, "_in_ready"}, {31'b0, bus_if.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.in_valid     = 1'b0;
        bus_if.in_exception = 1'b0;
        @(negedge clk);
        check({tag, "_lat1_valid"}, {31'b0, bus_if.out_valid}, 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, {31'b0, bus_if.out_valid}, 32'd1);
        check({tag, "_result"}, bus_if.out_result, want_res);
        check({tag, "_flags"}, flags(), {29'b0, want_flags});
    endtask

    // Backpressure stream
    logic [8:0]  bp_exp  [5];
    logic [47:0] bp_prod [5];
    logic        bp_sign [5];
    logic [31:0] bp_want [5];

    initial begin
        int sent;
        int rcv;
        int seen;

        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        bus_if.in_valid     = 1'b0;
        bus_if.in_sign      = 1'b0;
        bus_if.in_exp       = 9'd0;
        bus_if.in_product   = 48'd0;
        bus_if.in_exception = 1'b0;
        bus_if.out_ready    = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        check("rst_out_result", bus_if.out_result, 32'h0);
        check("rst_flags", flags(), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", {31'b0, bus_if.in_ready}, 32'd1);

        run_one("one_x_one", 1'b0, 9'd127, 48'h400000000000, 1'b0, 32'h3F800000, 3'b000);
        run_one("p1p5_sq", 1'b0, 9'd127, 48'h900000000000, 1'b0, 32'h40100000, 3'b000);
        run_one("n1p5_sq", 1'b1, 9'd127, 48'h900000000000, 1'b0, 32'hC0100000, 3'b000);
        run_one("rnd_carry", 1'b0, 9'd127, 48'h7FFFFFC00000, 1'b0, 32'h40000000, 3'b000);
        run_one("tie_even", 1'b0, 9'd127, 48'h400000400000, 1'b0, 32'h3F800000, 3'b000);
        // guard=1, sticky=1 must round up even with an even lsb
        run_one("rnd_sticky", 1'b0, 9'd127, 48'h400000400001, 1'b0, 32'h3F800001, 3'b000);
        run_one("ovf_254", 1'b0, 9'd254, 48'h800000000000, 1'b0, 32'h7F800000, 3'b100);
        run_one("max_norm", 1'b0, 9'd254, 48'h400000000000, 1'b0, 32'h7F000000, 3'b000);
        run_one("ovf_carry", 1'b1, 9'd254, 48'h7FFFFFC00000, 1'b0, 32'hFF800000, 3'b100);
        run_one("ovf_384", 1'b0, 9'd384, 48'h400000000000, 1'b0, 32'h7F800000, 3'b100);
        run_one("unf_400", 1'b0, 9'd400, 48'h400000000000, 1'b0, 32'h00000000, 3'b010);
        run_one("unf_385i", 1'b1, 9'd385, 48'h800000000000, 1'b0, 32'h80000000, 3'b010);
        run_one("unf_e0", 1'b0, 9'd0, 48'h400000000000, 1'b0, 32'h00000000, 3'b010);
        run_one("min_norm", 1'b0, 9'd0, 48'h800000000000, 1'b0, 32'h00800000, 3'b000);
        run_one("exc", 1'b1, 9'd254, 48'h800000000000, 1'b1, 32'h7FC00000, 3'b001);

        bp_exp[0] = 9'd127; bp_prod[0] = 48'h400000000000; bp_sign[0] = 1'b0;
        bp_want[0] = 32'h3F800000;
        bp_exp[1] = 9'd127; bp_prod[1] = 48'h900000000000; bp_sign[1] = 1'b0;
        bp_want[1] = 32'h40100000;
        bp_exp[2] = 9'd127; bp_prod[2] = 48'h900000000000; bp_sign[2] = 1'b1;
        bp_want[2] = 32'hC0100000;
        bp_exp[3] = 9'd127; bp_prod[3] = 48'h7FFFFFC00000; bp_sign[3] = 1'b0;
        bp_want[3] = 32'h40000000;
        bp_exp[4] = 9'd130; bp_prod[4] = 48'h600000000000; bp_sign[4] = 1'b0;
        bp_want[4] = 32'h41400000;

        sent = 0;
        rcv  = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bus_if.out_ready = !(cyc >= 2 && cyc <= 6);
            bus_if.in_valid  = (sent < 5);
            if (sent < 5) begin
                bus_if.in_sign    = bp_sign[sent];
                bus_if.in_exp     = bp_exp[sent];
                bus_if.in_product = bp_prod[sent];
            end
            #1;
            if (cyc == 3) begin
                check("bp_in_ready_low", {31'b0, bus_if.in_ready}, 32'd0);
                check("bp_held_items", sent, 32'd2);
            end
            if (bus_if.out_valid && rcv < 5) begin
                // Head of the queue must be on the outputs, stalled or not.
                check($sformatf("bp_item%0d", rcv), bus_if.out_result, bp_want[rcv]);
                if (bus_if.out_ready) rcv++;
            end else if (bus_if.out_valid) begin
                check("bp_extra_item", {31'b0, bus_if.out_valid}, 32'd0);
            end
            if (bus_if.in_valid && bus_if.in_ready) sent++;
            if (rcv == 5 && cyc > 10) break;
        end
        @(negedge clk);
        bus_if.in_valid = 1'b0;
        check("bp_received", rcv, 32'd5);
        @(negedge clk);
        check("bp_drained", {31'b0, bus_if.out_valid}, 32'd0);

        // Reset with two items in flight
        bus_if.out_ready  = 1'b0;
        bus_if.in_valid   = 1'b1;
        bus_if.in_sign    = 1'b0;
        bus_if.in_exp     = 9'd127;
        bus_if.in_product = 48'h400000000000;
        @(negedge clk);
        bus_if.in_product = 48'h900000000000;
        @(negedge clk);
        check("rs_full_valid", {31'b0, bus_if.out_valid}, 32'd1);
        bus_if.in_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check("rs_out_valid", {31'b0, bus_if.out_valid}, 32'd0);
        check("rs_out_result", bus_if.out_result, 32'h0);
        check("rs_in_ready", {31'b0, bus_if.in_ready}, 32'd1);
        reset = 1'b1;
        bus_if.out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus_if.out_valid) seen++;
        end
        check("rs_no_stale", seen, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fp_mul_norm_round.md
Name: fp_mul_norm_round

Overview:
- Downstream stage of the FP32 multiplier core.
- Consumes the raw sign, 9-bit biased exponent, 48-bit mantissa product and exception flag from the multiply stage; normalises, rounds to nearest-even and packs an IEEE-754 single-precision result.
- Two-stage pipeline with valid/ready handshake on both sides, so the vector multiplier lanes can stall without losing data.

Parameters:
- FLUSH_DENORM, 1, 1 = results with final exponent <= 0 flush to signed zero. This is the only supported value; 0 is reserved.
- QNAN, 32'h7FC00000, result word emitted when in_exception is set.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low
- in_valid  input  1  upstream data valid
- in_ready  output  1  block can accept in_* this cycle
- in_sign  input  1  product sign
- in_exp  input  9  biased exponent sum (ea+eb-127), modulo 512
- in_product  input  48  {1,ma}*{1,mb}
- in_exception  input  1  upstream exception flag
- out_valid  output  1  out_* valid
- out_ready  input  1  downstream accepts
- out_result  output  32  packed FP32 result
- out_overflow  output  1  result saturated to infinity
- out_underflow  output  1  result flushed to zero
- out_exception  output  1  pass-through of in_exception

Behaviour:
- Reset: when reset==0 at a clock edge, all stage valids clear. out_valid=0, out_result=0, out_overflow=0, out_underflow=0, out_exception=0. in_ready reads 1 the cycle after reset deasserts. A reset mid-operation discards all in-flight items.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Each stage loads when empty or when its successor is taking its contents.
  - in_ready = !s1_valid | s1_advance, combinational from out_ready.
  - Latency is 2 cycles with out_ready held high; throughput is 1 per cycle.
  - Outputs hold stable while out_valid & !out_ready.
- Stage 1 (normalise), registered:
  - If in_product[47]: mant=in_product[46:24], guard=[23], sticky=|[22:0], inc=1.
  - Else: mant=[45:23], guard=[22], sticky=|[21:0], inc=0.
  - Signed exponent e (11-bit signed): in_exp >= 385 is taken as in_exp-512, otherwise in_exp; then e = that value + inc.
- Stage 2 (round/pack), registered:
  - round_up = guard & (sticky | mant[0]).
  - mant_r = mant + round_up (24-bit). If mant_r[23], mantissa becomes 0 and e increments by 1.
- Priority of result classification:
  1. in_exception → out_result=QNAN, out_exception=1, other flags 0.
  2. e >= 255 → {sign, 8'hFF, 23'h0}, out_overflow=1.
  3. e <= 0 → {sign, 31'h0}, out_underflow=1.
  4. Otherwise → {sign, e[7:0], mant_r[22:0]}.
- Flags are per-item and travel with the data.
- Simultaneous in and out transfer when the pipeline is full is legal and loses nothing.

Test Plan:
- 1.0*1.0: in_exp=127, in_product=48'h400000000000, sign 0 → out_result=32'h3F800000 two cycles later, all flags 0.
- 1.5*1.5: in_exp=127, in_product=48'h900000000000 → 32'h40100000 (2.25). Negative sign gives 32'hC0100000.
- Round carry: in_exp=127, in_product=48'h7FFFFFC00000 → 32'h40000000. Tie-even: in_product=48'h400000400000 (guard=1, sticky=0, lsb=0) → 32'h3F800000.
- Range limits:
  - in_exp=254, in_product[47]=1 → 32'h7F800000 with out_overflow=1.
  - in_exp=9'd400 → 32'h00000000 with out_underflow=1.
  - in_exception=1 → 32'h7FC00000 with out_exception=1.
- Backpressure: stream 5 items with out_ready=0 for cycles 2–6. in_ready drops after 2 items are held. On release, all 5 results appear in order with no duplicates, and outputs stay stable during the stall.
- Reset mid-stream: assert reset=0 with 2 items in flight → out_valid=0 the next cycle, no stale result emitted after reset releases.
